iagc_gain_controller: RTL and testbench

- Downstream stage of the IAGC amplitude detector.
- Consumes each new reference/error amplitude pair and compares error to reference within a tolerance band.
- Steps a saturating gain register up or down, then holds a settle window so the gain change can propagate before the next measurement.
- Drives the variable-gain stage and reports lock/saturation status.

---
 rtl/iagc_gain_controller.sv | 199 +++++++++++++++++++
 tb/tb_iagc_gain_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/iagc_gain_controller.sv
// IAGC gain controller: compares error against reference amplitude, steps a clamped gain and holds a settle window.
// Optional proportional step size is enabled by defining IAGC_GAIN_PROPORTIONAL_EN.
module iagc_gain_controller #(
   parameter int IAGC_STATUS_SIZE  = 4,
   parameter int SAMPLER_DATA_SIZE = 16,
   parameter int GAIN_SIZE         = 8,
   parameter int GAIN_INIT         = 128,
   parameter int GAIN_MIN          = 1,
   parameter int GAIN_MAX          = 255,
   parameter int SETTLE_COUNT_SIZE = 16,
   parameter int LOCK_COUNT        = 4
`ifdef IAGC_GAIN_PROPORTIONAL_EN
   ,
   parameter int PROP_SHIFT        = 4
`endif
) (
   input  logic                         i_clock,
   input  logic                         i_reset_n,
   input  logic [IAGC_STATUS_SIZE-1:0]  i_iagc_status,
   input  logic                         i_amplitude_valid,
   input  logic [SAMPLER_DATA_SIZE-1:0] i_reference_amplitude,
   input  logic [SAMPLER_DATA_SIZE-1:0] i_error_amplitude,
   input  logic [SAMPLER_DATA_SIZE-1:0] i_tolerance,
   input  logic [GAIN_SIZE-1:0]         i_step,
   input  logic [SETTLE_COUNT_SIZE-1:0] i_settle_cycles,
   output logic [GAIN_SIZE-1:0]         o_gain,
   output logic                         o_gain_update,
   output logic                         o_locked,
   output logic                         o_saturated
);
   localparam int LOCK_W = $clog2(LOCK_COUNT + 1);
   localparam logic [GAIN_SIZE-1:0] GAIN_INIT_W = GAIN_INIT[GAIN_SIZE-1:0];
   localparam logic [GAIN_SIZE-1:0] GAIN_MIN_W  = GAIN_MIN[GAIN_SIZE-1:0];
   localparam logic [GAIN_SIZE-1:0] GAIN_MAX_W  = GAIN_MAX[GAIN_SIZE-1:0];
   localparam logic [GAIN_SIZE:0]   GAIN_MIN_X  = {1'b0, GAIN_MIN_W};
   localparam logic [GAIN_SIZE:0]   GAIN_MAX_X  = {1'b0, GAIN_MAX_W};
   localparam logic [LOCK_W-1:0]    LOCK_FULL   = LOCK_COUNT[LOCK_W-1:0];
   localparam logic SAT_INIT = (GAIN_INIT == GAIN_MIN) || (GAIN_INIT == GAIN_MAX);

   typedef enum logic [1:0] {IDLE, COMPARE, ADJUST, SETTLE} state_t;

   state_t                         state_reg, state_next;
   logic [SAMPLER_DATA_SIZE-1:0]   ref_reg, ref_next;
   logic [SAMPLER_DATA_SIZE-1:0]   err_reg, err_next;
   logic                           dir_up_reg, dir_up_next;
   logic [LOCK_W-1:0]              lock_cnt_reg, lock_cnt_next;
   logic                           locked_reg, locked_next;
   logic [GAIN_SIZE-1:0]           gain_reg, gain_next;
   logic                           gain_update_reg, gain_update_next;
   logic                           saturated_reg, saturated_next;
   logic [SETTLE_COUNT_SIZE-1:0]   settle_cnt_reg, settle_cnt_next;

   logic [SAMPLER_DATA_SIZE:0]     err_plus_tol, ref_plus_tol;
   logic                           below_band, above_band;
   logic [GAIN_SIZE-1:0]           step_eff;
   logic [GAIN_SIZE:0]             gain_wide;
   logic [GAIN_SIZE-1:0]           gain_clamped;

   always_comb begin
      err_plus_tol = {1'b0, err_reg} + {1'b0, i_tolerance};
      ref_plus_tol = {1'b0, ref_reg} + {1'b0, i_tolerance};
      below_band   = err_plus_tol < {1'b0, ref_reg};
      above_band   = {1'b0, err_reg} > ref_plus_tol;
   end

`ifdef IAGC_GAIN_PROPORTIONAL_EN
   logic [SAMPLER_DATA_SIZE:0] diff_s, abs_diff_reg, shifted;
   logic [GAIN_SIZE-1:0]       prop_step;

   always_comb begin
      diff_s    = {1'b0, err_reg} - {1'b0, ref_reg};
      shifted   = abs_diff_reg >> PROP_SHIFT;
      prop_step = (shifted > {{(SAMPLER_DATA_SIZE+1-GAIN_SIZE){1'b0}}, {GAIN_SIZE{1'b1}}})
                  ? {GAIN_SIZE{1'b1}} : shifted[GAIN_SIZE-1:0];
      step_eff  = (prop_step > i_step) ? prop_step : i_step;
   end

   // |diff| is captured on the compare edge and consumed in ADJUST
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n)
         abs_diff_reg <= '0;
      else if (i_iagc_status == '0)
         abs_diff_reg <= '0;
      else if (state_reg == COMPARE)
         abs_diff_reg <= diff_s[SAMPLER_DATA_SIZE] ? -diff_s : diff_s;
   end
`else
   assign step_eff = i_step;
`endif

   // Down-steps larger than the current gain would wrap, so they clamp straight to the floor
   always_comb begin
      if (dir_up_reg)
         gain_wide = {1'b0, gain_reg} + {1'b0, step_eff};
      else
         gain_wide = {1'b0, gain_reg} - {1'b0, step_eff};
      if (!dir_up_reg && (step_eff > gain_reg))
         gain_clamped = GAIN_MIN_W;
      else if (gain_wide > GAIN_MAX_X)
         gain_clamped = GAIN_MAX_W;
      else if (gain_wide < GAIN_MIN_X)
         gain_clamped = GAIN_MIN_W;
      else
         gain_clamped = gain_wide[GAIN_SIZE-1:0];
   end

   always_comb begin
      state_next       = state_reg;
      ref_next         = ref_reg;
      err_next         = err_reg;
      dir_up_next      = dir_up_reg;
      lock_cnt_next    = lock_cnt_reg;
      locked_next      = locked_reg;
      gain_next        = gain_reg;
      gain_update_next = 1'b0;
      saturated_next   = saturated_reg;
      settle_cnt_next  = settle_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (i_amplitude_valid) begin
               ref_next   = i_reference_amplitude;
               err_next   = i_error_amplitude;
               state_next = COMPARE;
            end
         end
         COMPARE: begin
            if (below_band || above_band) begin
               dir_up_next   = below_band;
               lock_cnt_next = '0;
               locked_next   = 1'b0;
               state_next    = ADJUST;
            end else begin
               if (lock_cnt_reg != LOCK_FULL)
                  lock_cnt_next = lock_cnt_reg + LOCK_W'(1);
               locked_next = (lock_cnt_next == LOCK_FULL);
               state_next  = IDLE;
            end
         end
         ADJUST: begin
            gain_next        = gain_clamped;
            gain_update_next = (gain_clamped != gain_reg);
            saturated_next   = (gain_clamped == GAIN_MIN_W) || (gain_clamped == GAIN_MAX_W);
            settle_cnt_next  = i_settle_cycles;
            state_next       = SETTLE;
         end
         SETTLE: begin
            // A zero settle count still spends one cycle here
            if (settle_cnt_reg != '0)
               settle_cnt_next = settle_cnt_reg - SETTLE_COUNT_SIZE'(1);
            if (settle_cnt_reg <= SETTLE_COUNT_SIZE'(1))
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (i_iagc_status == '0) begin
         state_next       = IDLE;
         ref_next         = '0;
         err_next         = '0;
         dir_up_next      = 1'b0;
         lock_cnt_next    = '0;
         locked_next      = 1'b0;
         gain_next        = GAIN_INIT_W;
         gain_update_next = 1'b0;
         saturated_next   = SAT_INIT;
         settle_cnt_next  = '0;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_reg       <= IDLE;
         ref_reg         <= '0;
         err_reg         <= '0;
         dir_up_reg      <= 1'b0;
         lock_cnt_reg    <= '0;
         locked_reg      <= 1'b0;
         gain_reg        <= GAIN_INIT_W;
         gain_update_reg <= 1'b0;
         saturated_reg   <= SAT_INIT;
         settle_cnt_reg  <= '0;
      end else begin
         state_reg       <= state_next;
         ref_reg         <= ref_next;
         err_reg         <= err_next;
         dir_up_reg      <= dir_up_next;
         lock_cnt_reg    <= lock_cnt_next;
         locked_reg      <= locked_next;
         gain_reg        <= gain_next;
         gain_update_reg <= gain_update_next;
         saturated_reg   <= saturated_next;
         settle_cnt_reg  <= settle_cnt_next;
      end
   end

   assign o_gain        = gain_reg;
   assign o_gain_update = gain_update_reg;
   assign o_locked      = locked_reg;
   assign o_saturated   = saturated_reg;
endmodule

// File: tb/tb_iagc_gain_controller.sv
// Self-checking bench for iagc_gain_controller: directed steps plus random measurements against a behavioural model.
module tb_iagc_gain_controller;
   logic        i_clock = 1'b0;
   logic        i_reset_n;
   logic [3:0]  i_iagc_status;
   logic        i_amplitude_valid;
   logic [15:0] i_reference_amplitude;
   logic [15:0] i_error_amplitude;
   logic [15:0] i_tolerance;
   logic [7:0]  i_step;
   logic [15:0] i_settle_cycles;
   logic [7:0]  o_gain;
   logic        o_gain_update;
   logic        o_locked;
   logic        o_saturated;

   iagc_gain_controller dut (
      .i_clock               (i_clock),
      .i_reset_n             (i_reset_n),
      .i_iagc_status         (i_iagc_status),
      .i_amplitude_valid     (i_amplitude_valid),
      .i_reference_amplitude (i_reference_amplitude),
      .i_error_amplitude     (i_error_amplitude),
      .i_tolerance           (i_tolerance),
      .i_step                (i_step),
      .i_settle_cycles       (i_settle_cycles),
      .o_gain                (o_gain),
      .o_gain_update         (o_gain_update),
      .o_locked              (o_locked),
      .o_saturated           (o_saturated)
   );

   always #5 i_clock = ~i_clock;

   int errors = 0;
   int checks = 0;
   int m_gain = 128;
   int m_lock = 0;
   int m_locked = 0;

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle_reset_values(input string tag);
      check({tag, "_gain"}, 32'(o_gain), 128);
      check({tag, "_locked"}, 32'(o_locked), 0);
      check({tag, "_update"}, 32'(o_gain_update), 0);
      check({tag, "_sat"}, 32'(o_saturated), 0);
   endtask

   // Called at a negedge whose following posedge must accept the valid.
   // inject: 0 none, 1 valid pulse on the last settle edge, 2 IAGC status reset in settle.
   task automatic measure(input int r, input int e, input int t, input int s, input int st, input int inject);
      int  old_gain, eff, hold, p;
      bit  up, inband;
      i_reference_amplitude = 16'(r);
      i_error_amplitude     = 16'(e);
      i_tolerance           = 16'(t);
      i_step                = 8'(s);
      i_settle_cycles       = 16'(st);
      i_amplitude_valid     = 1'b1;
      @(negedge i_clock);
      i_amplitude_valid = 1'b0;
      up     = (e + t < r);
      inband = !up && !(e > r + t);
      if (inband) begin
         m_lock   = (m_lock < 4) ? m_lock + 1 : 4;
         m_locked = (m_lock == 4) ? 1 : 0;
      end else begin
         m_lock   = 0;
         m_locked = 0;
      end
      @(negedge i_clock);
      check("locked", 32'(o_locked), m_locked);
      if (inband) begin
         check("gain_hold", 32'(o_gain), m_gain);
         check("update_hold", 32'(o_gain_update), 0);
         $display("meas ref=%0d err=%0d tol=%0d in-band gain=%0d locked=%0d", r, e, t, o_gain, o_locked);
         return;
      end
      eff = s;
`ifdef IAGC_GAIN_PROPORTIONAL_EN
      p = ((e > r) ? e - r : r - e) >> 4;
      if (p > 255) p = 255;
      if (p > eff) eff = p;
`else
      p = 0;
`endif
      old_gain = m_gain;
      m_gain   = up ? m_gain + eff : m_gain - eff;
      if (m_gain > 255) m_gain = 255;
      if (m_gain < 1) m_gain = 1;
      @(negedge i_clock);
      check("gain", 32'(o_gain), m_gain);
      check("update", 32'(o_gain_update), int'(m_gain != old_gain));
      check("saturated", 32'(o_saturated), int'(m_gain == 1 || m_gain == 255));
      $display("meas ref=%0d err=%0d tol=%0d step=%0d gain %0d->%0d upd=%0d sat=%0d",
               r, e, t, eff, old_gain, o_gain, o_gain_update, o_saturated);
      @(negedge i_clock);
      check("update_end", 32'(o_gain_update), 0);
      hold = (st < 1) ? 1 : st;
      if (inject == 1 && hold >= 2) begin
         repeat (hold - 2) @(negedge i_clock);
         i_reference_amplitude = 16'd0;
         i_error_amplitude     = 16'd60000;
         i_amplitude_valid     = 1'b1;
         @(negedge i_clock);
         i_amplitude_valid = 1'b0;
         check("dropped_gain", 32'(o_gain), m_gain);
         check("dropped_update", 32'(o_gain_update), 0);
         $display("dropped valid during settle, gain=%0d", o_gain);
      end else if (inject == 2) begin
         i_iagc_status = 4'b0000;
         @(negedge i_clock);
         i_iagc_status = 4'b0001;
         m_gain = 128; m_lock = 0; m_locked = 0;
         check_idle_reset_values("status_reset");
         $display("IAGC status reset in settle, gain=%0d", o_gain);
      end else begin
         repeat (hold - 1) @(negedge i_clock);
      end
   endtask

   task automatic async_abort(input int r, input int e, input int t, input int s);
      i_reference_amplitude = 16'(r);
      i_error_amplitude     = 16'(e);
      i_tolerance           = 16'(t);
      i_step                = 8'(s);
      i_settle_cycles       = 16'd3;
      i_amplitude_valid     = 1'b1;
      @(negedge i_clock);
      i_amplitude_valid = 1'b0;
      @(negedge i_clock);
      #2 i_reset_n = 1'b0;
      #1;
      m_gain = 128; m_lock = 0; m_locked = 0;
      check_idle_reset_values("async_reset");
      $display("async reset in ADJUST, gain=%0d", o_gain);
      @(negedge i_clock);
      i_reset_n = 1'b1;
      @(negedge i_clock);
   endtask

   initial begin
      i_reset_n             = 1'b0;
      i_iagc_status         = 4'b0000;
      i_amplitude_valid     = 1'b0;
      i_reference_amplitude = '0;
      i_error_amplitude     = '0;
      i_tolerance           = '0;
      i_step                = '0;
      i_settle_cycles       = '0;
      repeat (2) @(negedge i_clock);
      check_idle_reset_values("reset");
      i_reset_n = 1'b1;
      @(negedge i_clock);
      i_iagc_status = 4'b0001;
      @(negedge i_clock);

      measure(1000, 500, 50, 4, 10, 0);
      measure(1000, 500, 50, 4, 10, 1);
      measure(1000, 1500, 50, 4, 3, 0);
      for (int k = 0; k < 36; k++)
         measure(1000, 1500, 50, 4, 0, 0);
      for (int k = 0; k < 4; k++)
         measure(1000, 1030, 50, 4, 2, 0);
      measure(1000, 1200, 50, 4, 2, 0);
      measure(1000, 500, 50, 199, 5, 2);
      measure(1000, 500, 50, 10, 1, 0);
      async_abort(1000, 1500, 50, 4);
      measure(1000, 0, 0, 1, 2, 0);
      for (int k = 0; k < 40; k++)
         measure(int'($urandom_range(0, 3000)), int'($urandom_range(0, 3000)),
                 int'($urandom_range(0, 200)), int'($urandom_range(0, 40)),
                 int'($urandom_range(0, 4)), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
